// File: rtl/ascon_dec_fsm_if.sv
// Handshake/control bundle between the Ascon-128 decryption controller and its datapath/FIFOs.
// The controller side uses the slave modport; the environment (datapath, FIFOs, host) uses master.
interface ascon_dec_fsm_if #(
    parameter int CNT_W   = 8,
    parameter int DELAY_W = 8
);
    logic               start_i;
    logic [CNT_W-1:0]   ad_blocks_i;
    logic [CNT_W-1:0]   ct_blocks_i;
    logic [DELAY_W-1:0] delay_i;
    logic               ready_o;
    logic               ad_empty_i;
    logic               ad_pop_o;
    logic               ad_flush_o;
    logic               ct_empty_i;
    logic               ct_pop_o;
    logic               ct_flush_o;
    logic               pt_full_i;
    logic               pt_push_o;
    logic               pt_flush_o;
    logic               load_state_o;
    logic               sel_state_init_o;
    logic               sel_xor_init_o;
    logic               sel_xor_ext_o;
    logic               sel_ct_replace_o;
    logic               sel_xor_dom_sep_o;
    logic               sel_xor_fin_o;
    logic               sel_xor_tag_o;
    logic               sel_ad_o;
    logic               tag_match_i;
    logic               pt_valid_o;
    logic               auth_ok_o;
    logic               auth_fail_o;

    modport slave (
        input  start_i, ad_blocks_i, ct_blocks_i, delay_i,
        input  ad_empty_i, ct_empty_i, pt_full_i, tag_match_i,
        output ready_o, ad_pop_o, ad_flush_o, ct_pop_o, ct_flush_o, pt_push_o, pt_flush_o,
        output load_state_o, sel_state_init_o, sel_xor_init_o, sel_xor_ext_o, sel_ct_replace_o,
        output sel_xor_dom_sep_o, sel_xor_fin_o, sel_xor_tag_o, sel_ad_o,
        output pt_valid_o, auth_ok_o, auth_fail_o
    );

    modport master (
        output start_i, ad_blocks_i, ct_blocks_i, delay_i,
        output ad_empty_i, ct_empty_i, pt_full_i, tag_match_i,
        input  ready_o, ad_pop_o, ad_flush_o, ct_pop_o, ct_flush_o, pt_push_o, pt_flush_o,
        input  load_state_o, sel_state_init_o, sel_xor_init_o, sel_xor_ext_o, sel_ct_replace_o,
        input  sel_xor_dom_sep_o, sel_xor_fin_o, sel_xor_tag_o, sel_ad_o,
        input  pt_valid_o, auth_ok_o, auth_fail_o
    );
endinterface

// File: rtl/ascon_dec_fsm.sv
// Ascon-128 decryption control FSM: init, AD absorb, CT->PT, finalisation and tag verdict.
// Define ASCON_DEC_PT_GATE_EN to withhold plaintext release until the tag has been verified.
module ascon_dec_fsm #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6,
    parameter int CNT_W    = 8,
    parameter int DELAY_W  = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    ascon_dec_fsm_if.slave     bus
);
    localparam int RND_MAX = (ROUNDS_A > ROUNDS_B) ? ROUNDS_A : ROUNDS_B;
    localparam int RND_W   = $clog2(RND_MAX + 1);

    typedef enum logic [4:0] {
        S_IDLE         = 5'd0,
        S_START        = 5'd1,
        S_WAIT_DELAY   = 5'd2,
        S_INI_STA      = 5'd3,
        S_INI_MID      = 5'd4,
        S_INI_END      = 5'd5,
        S_WAIT_AD      = 5'd6,
        S_AD_STA       = 5'd7,
        S_AD_MID       = 5'd8,
        S_AD_END       = 5'd9,
        S_WAIT_CT      = 5'd10,
        S_CT_STA       = 5'd11,
        S_CT_MID       = 5'd12,
        S_CT_END       = 5'd13,
        S_WAIT_LAST_CT = 5'd14,
        S_FIN_STA      = 5'd15,
        S_FIN_MID      = 5'd16,
        S_FIN_END      = 5'd17,
        S_CHECK        = 5'd18,
        S_DONE         = 5'd19
    } state_t;

    state_t             state_q, state_d;
    logic [RND_W-1:0]   round_q, round_d;
    logic [DELAY_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0]   ad_rem_q, ad_rem_d;
    logic [CNT_W-1:0]   ct_rem_q, ct_rem_d;
    logic               flag_q, flag_d;

    logic ready_s, ad_pop_s, ad_flush_s, ct_pop_s, ct_flush_s, pt_push_s, pt_flush_s;
    logic load_state_s, sel_state_init_s, sel_xor_init_s, sel_xor_ext_s, sel_ct_replace_s;
    logic sel_xor_dom_sep_s, sel_xor_fin_s, sel_xor_tag_s, sel_ad_s;
    logic pt_valid_s, auth_ok_s, auth_fail_s;
    logic io_ready_s;

    // After the domain separator the last CT block always goes through the p^a path.
    function automatic state_t ct_entry(input logic [CNT_W-1:0] rem);
        return (rem == CNT_W'(1)) ? S_WAIT_LAST_CT : S_WAIT_CT;
    endfunction

    assign io_ready_s = !bus.ct_empty_i && !bus.pt_full_i;

    // Next-state, counter updates and state-decoded outputs.
    always_comb begin
        state_d           = state_q;
        round_d           = round_q;
        timer_d           = timer_q;
        ad_rem_d          = ad_rem_q;
        ct_rem_d          = ct_rem_q;
        flag_d            = flag_q;
        ready_s           = 1'b0;
        ad_pop_s          = 1'b0;
        ad_flush_s        = 1'b0;
        ct_pop_s          = 1'b0;
        ct_flush_s        = 1'b0;
        pt_push_s         = 1'b0;
        pt_flush_s        = 1'b0;
        load_state_s      = 1'b0;
        sel_state_init_s  = 1'b0;
        sel_xor_init_s    = 1'b0;
        sel_xor_ext_s     = 1'b0;
        sel_ct_replace_s  = 1'b0;
        sel_xor_dom_sep_s = 1'b0;
        sel_xor_fin_s     = 1'b0;
        sel_xor_tag_s     = 1'b0;
        sel_ad_s          = 1'b0;
        pt_valid_s        = 1'b0;
        auth_ok_s         = 1'b0;
        auth_fail_s       = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_s    = 1'b1;
                ad_flush_s = 1'b1;
                ct_flush_s = 1'b1;
                pt_flush_s = 1'b1;
                state_d    = bus.start_i ? S_START : S_IDLE;
            end
            S_START: begin
                ad_rem_d = bus.ad_blocks_i;
                ct_rem_d = (bus.ct_blocks_i == CNT_W'(0)) ? CNT_W'(1) : bus.ct_blocks_i;
                round_d  = RND_W'(ROUNDS_A);
                timer_d  = bus.delay_i;
                state_d  = S_WAIT_DELAY;
            end
            S_WAIT_DELAY: begin
                if (timer_q == DELAY_W'(0)) begin
                    state_d = S_INI_STA;
                end else begin
                    timer_d = timer_q - DELAY_W'(1);
                end
            end
            S_INI_STA: begin
                load_state_s     = 1'b1;
                sel_state_init_s = 1'b1;
                round_d          = round_q - RND_W'(1);
                state_d          = S_INI_MID;
            end
            S_INI_MID: begin
                load_state_s = 1'b1;
                round_d      = round_q - RND_W'(1);
                state_d      = (round_q == RND_W'(1)) ? S_INI_END : S_INI_MID;
            end
            S_INI_END: begin
                load_state_s   = 1'b1;
                sel_xor_init_s = 1'b1;
                if (ad_rem_q == CNT_W'(0)) begin
                    sel_xor_dom_sep_s = 1'b1;
                    state_d           = ct_entry(ct_rem_q);
                end else begin
                    state_d = S_WAIT_AD;
                end
            end
            S_WAIT_AD: begin
                round_d = RND_W'(ROUNDS_B);
                state_d = bus.ad_empty_i ? S_WAIT_AD : S_AD_STA;
            end
            S_AD_STA: begin
                load_state_s  = 1'b1;
                sel_ad_s      = 1'b1;
                sel_xor_ext_s = 1'b1;
                ad_pop_s      = 1'b1;
                ad_rem_d      = ad_rem_q - CNT_W'(1);
                round_d       = round_q - RND_W'(1);
                state_d       = S_AD_MID;
            end
            S_AD_MID: begin
                load_state_s = 1'b1;
                round_d      = round_q - RND_W'(1);
                state_d      = (round_q == RND_W'(1)) ? S_AD_END : S_AD_MID;
            end
            S_AD_END: begin
                load_state_s = 1'b1;
                if (ad_rem_q == CNT_W'(0)) begin
                    sel_xor_dom_sep_s = 1'b1;
                    state_d           = ct_entry(ct_rem_q);
                end else begin
                    state_d = S_WAIT_AD;
                end
            end
            S_WAIT_CT: begin
                round_d = RND_W'(ROUNDS_B);
                state_d = io_ready_s ? S_CT_STA : S_WAIT_CT;
            end
            S_CT_STA: begin
                load_state_s     = 1'b1;
                sel_xor_ext_s    = 1'b1;
                sel_ct_replace_s = 1'b1;
                ct_pop_s         = 1'b1;
                pt_push_s        = 1'b1;
                ct_rem_d         = ct_rem_q - CNT_W'(1);
                round_d          = round_q - RND_W'(1);
                state_d          = S_CT_MID;
            end
            S_CT_MID: begin
                load_state_s = 1'b1;
                round_d      = round_q - RND_W'(1);
                state_d      = (round_q == RND_W'(1)) ? S_CT_END : S_CT_MID;
            end
            S_CT_END: begin
                load_state_s = 1'b1;
                state_d      = ct_entry(ct_rem_q);
            end
            S_WAIT_LAST_CT: begin
                round_d = RND_W'(ROUNDS_A);
                state_d = io_ready_s ? S_FIN_STA : S_WAIT_LAST_CT;
            end
            S_FIN_STA: begin
                load_state_s     = 1'b1;
                sel_xor_ext_s    = 1'b1;
                sel_ct_replace_s = 1'b1;
                sel_xor_fin_s    = 1'b1;
                ct_pop_s         = 1'b1;
                pt_push_s        = 1'b1;
                ct_rem_d         = ct_rem_q - CNT_W'(1);
                round_d          = round_q - RND_W'(1);
                state_d          = S_FIN_MID;
            end
            S_FIN_MID: begin
                load_state_s = 1'b1;
                round_d      = round_q - RND_W'(1);
                state_d      = (round_q == RND_W'(1)) ? S_FIN_END : S_FIN_MID;
            end
            S_FIN_END: begin
                load_state_s  = 1'b1;
                sel_xor_tag_s = 1'b1;
                state_d       = S_CHECK;
            end
            S_CHECK: begin
                flag_d  = bus.tag_match_i;
`ifdef ASCON_DEC_PT_GATE_EN
                pt_flush_s = !bus.tag_match_i;
`endif
                state_d = S_DONE;
            end
            S_DONE: begin
                auth_ok_s   = flag_q;
                auth_fail_s = !flag_q;
`ifdef ASCON_DEC_PT_GATE_EN
                pt_valid_s  = flag_q;
`endif
                state_d     = bus.start_i ? S_DONE : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifndef ASCON_DEC_PT_GATE_EN
        pt_valid_s = pt_push_s;
`endif
    end

    // State and counter registers; reset returns to IDLE with everything cleared.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            round_q  <= RND_W'(0);
            timer_q  <= DELAY_W'(0);
            ad_rem_q <= CNT_W'(0);
            ct_rem_q <= CNT_W'(0);
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            timer_q  <= timer_d;
            ad_rem_q <= ad_rem_d;
            ct_rem_q <= ct_rem_d;
            flag_q   <= flag_d;
        end
    end

    assign bus.ready_o           = ready_s;
    assign bus.ad_pop_o          = ad_pop_s;
    assign bus.ad_flush_o        = ad_flush_s;
    assign bus.ct_pop_o          = ct_pop_s;
    assign bus.ct_flush_o        = ct_flush_s;
    assign bus.pt_push_o         = pt_push_s;
    assign bus.pt_flush_o        = pt_flush_s;
    assign bus.load_state_o      = load_state_s;
    assign bus.sel_state_init_o  = sel_state_init_s;
    assign bus.sel_xor_init_o    = sel_xor_init_s;
    assign bus.sel_xor_ext_o     = sel_xor_ext_s;
    assign bus.sel_ct_replace_o  = sel_ct_replace_s;
    assign bus.sel_xor_dom_sep_o = sel_xor_dom_sep_s;
    assign bus.sel_xor_fin_o     = sel_xor_fin_s;
    assign bus.sel_xor_tag_o     = sel_xor_tag_s;
    assign bus.sel_ad_o          = sel_ad_s;
    assign bus.pt_valid_o        = pt_valid_s;
    assign bus.auth_ok_o         = auth_ok_s;
    assign bus.auth_fail_o       = auth_fail_s;
endmodule

// File: tb/tb_ascon_dec_fsm.sv
// Self-checking bench for ascon_dec_fsm: directed corner cases plus randomized runs with
// FIFO occupancy models, checked against block/latency arithmetic derived from the protocol.
module tb_ascon_dec_fsm;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

`ifdef ASCON_DEC_PT_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    always #5 clk = ~clk;

    ascon_dec_fsm_if #(.CNT_W(8), .DELAY_W(8)) bus_if ();

    ascon_dec_fsm #(.ROUNDS_A(12), .ROUNDS_B(6), .CNT_W(8), .DELAY_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_ready"}, int'(bus_if.ready_o), 1);
        check_eq({tag, "_flushes"}, int'(bus_if.ad_flush_o) + int'(bus_if.ct_flush_o) + int'(bus_if.pt_flush_o), 3);
        check_eq({tag, "_auth"}, int'(bus_if.auth_ok_o) + int'(bus_if.auth_fail_o), 0);
        check_eq({tag, "_load"}, int'(bus_if.load_state_o), 0);
    endtask

    // One full decryption; expectations come from block counts and per-phase cycle costs.
    task automatic run_case(input string name, input int ad, input int ct, input int d, input bit tag,
                            input bit rnd, input int full_until, input int extra, input int rst_at);
        int ct_eff, exp_lat, t;
        int n_adp, n_ctp, n_push, n_dom, n_valid, n_flush, n_viol, n_win;
        int ad_av, ct_av, pt_sp;
        bit done_seen;
        ct_eff  = (ct == 0) ? 1 : ct;
        exp_lat = 31 + d + 8 * ad + 8 * (ct_eff - 1) + extra;
        n_adp = 0; n_ctp = 0; n_push = 0; n_dom = 0; n_valid = 0; n_flush = 0; n_viol = 0; n_win = 0;
        ad_av = rnd ? 0 : 1000;
        ct_av = rnd ? 0 : 1000;
        pt_sp = rnd ? 1 : 1000;
        check_eq({name, "_pre_ready"}, int'(bus_if.ready_o), 1);
        bus_if.ad_blocks_i = 8'(ad);
        bus_if.ct_blocks_i = 8'(ct);
        bus_if.delay_i     = 8'(d);
        bus_if.tag_match_i = tag;
        bus_if.ad_empty_i  = (ad_av == 0);
        bus_if.ct_empty_i  = (ct_av == 0);
        bus_if.pt_full_i   = (pt_sp == 0) || (full_until >= 0);
        bus_if.start_i     = 1'b1;
        t = 0;
        done_seen = 1'b0;
        while (!done_seen && t < 3000) begin
            @(posedge clk); #1;
            t++;
            if (t == rst_at) begin
                rst = 1'b1;
                #1;
                check_idle({name, "_rst"});
                bus_if.start_i = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                check_idle({name, "_postrst"});
                return;
            end
            if (bus_if.ad_pop_o) begin
                n_adp++;
                if (bus_if.ad_empty_i || ad_av == 0) n_viol++; else ad_av--;
            end
            if (bus_if.ct_pop_o) begin
                n_ctp++;
                if (bus_if.ct_empty_i || ct_av == 0) n_viol++; else ct_av--;
            end
            if (bus_if.pt_push_o) begin
                n_push++;
                if (bus_if.pt_full_i || pt_sp == 0) n_viol++; else pt_sp--;
            end
            n_dom += int'(bus_if.sel_xor_dom_sep_o);
            if (bus_if.pt_valid_o && !(bus_if.auth_ok_o || bus_if.auth_fail_o)) n_valid++;
            if (bus_if.pt_flush_o && !bus_if.ready_o) n_flush++;
            if (t >= 16 && t <= full_until + 1) n_win += int'(bus_if.load_state_o) + int'(bus_if.pt_push_o);
            if (bus_if.auth_ok_o || bus_if.auth_fail_o) begin
                done_seen = 1'b1;
            end else begin
                if (rnd && $urandom_range(0, 2) == 0) ad_av++;
                if (rnd && $urandom_range(0, 2) == 0) ct_av++;
                if (rnd && $urandom_range(0, 2) == 0) pt_sp++;
                bus_if.ad_empty_i = (ad_av == 0);
                bus_if.ct_empty_i = (ct_av == 0);
                bus_if.pt_full_i  = (pt_sp == 0) || (t <= full_until);
            end
        end
        check_eq({name, "_done_seen"}, int'(done_seen), 1);
        check_eq({name, "_auth_ok"}, int'(bus_if.auth_ok_o), int'(tag));
        check_eq({name, "_auth_fail"}, int'(bus_if.auth_fail_o), int'(!tag));
        check_eq({name, "_valid_done"}, int'(bus_if.pt_valid_o), int'(GATE && tag));
        if (!rnd) check_eq({name, "_latency"}, t, exp_lat);
        else check_eq({name, "_latency_min"}, int'(t >= exp_lat), 1);
        check_eq({name, "_ad_pops"}, n_adp, ad);
        check_eq({name, "_ct_pops"}, n_ctp, ct_eff);
        check_eq({name, "_pt_pushes"}, n_push, ct_eff);
        check_eq({name, "_dom_sep"}, n_dom, 1);
        check_eq({name, "_pt_valid"}, n_valid, GATE ? 0 : ct_eff);
        check_eq({name, "_pt_flush"}, n_flush, int'(GATE && !tag));
        check_eq({name, "_fifo_viol"}, n_viol, 0);
        check_eq({name, "_stall_activity"}, n_win, 0);
        repeat (2) begin
            @(posedge clk); #1;
            check_eq({name, "_held"}, int'(bus_if.auth_ok_o) + int'(bus_if.auth_fail_o), 1);
        end
        bus_if.start_i = 1'b0;
        @(posedge clk); #1;
        check_idle({name, "_ack"});
    endtask

    initial begin
        rst                = 1'b1;
        bus_if.start_i     = 1'b0;
        bus_if.ad_blocks_i = 8'd0;
        bus_if.ct_blocks_i = 8'd0;
        bus_if.delay_i     = 8'd0;
        bus_if.ad_empty_i  = 1'b1;
        bus_if.ct_empty_i  = 1'b1;
        bus_if.pt_full_i   = 1'b0;
        bus_if.tag_match_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle("idle");

        run_case("basic",   0, 1, 0, 1'b1, 1'b0, -1, 0, -1);
        run_case("ad2ct3",  2, 3, 1, 1'b0, 1'b0, -1, 0, -1);
        run_case("ptfull",  0, 2, 0, 1'b1, 1'b0, 25, 10, -1);
        run_case("ct0",     1, 0, 2, 1'b1, 1'b0, -1, 0, -1);
        run_case("ct1",     1, 1, 2, 1'b1, 1'b0, -1, 0, -1);
        run_case("rstfin",  0, 1, 0, 1'b1, 1'b0, -1, 0, 22);
        run_case("afterrst",0, 1, 0, 1'b0, 1'b0, -1, 0, -1);
        run_case("delay",   3, 2, 7, 1'b0, 1'b0, -1, 0, -1);

        for (int i = 0; i < 24; i++) begin
            run_case($sformatf("rand%0d", i), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 1'(i % 2), -1, 0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
